execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv_pkg.sv | 24 ++
 rtl/execute_muldiv_if.sv | 25 ++
 rtl/muldiv_div_core.sv | 64 ++++++
 rtl/execute_muldiv.sv | 177 +++++++++++++++++
 tb/tb_execute_muldiv.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states, op width.
package execute_muldiv_pkg;

    localparam int unsigned OpWidth = 32;

    typedef enum logic [2:0] {
        F3Mul    = 3'b000,
        F3Mulh   = 3'b001,
        F3Mulhsu = 3'b010,
        F3Mulhu  = 3'b011,
        F3Div    = 3'b100,
        F3Divu   = 3'b101,
        F3Rem    = 3'b110,
        F3Remu   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

endpackage

// File: rtl/execute_muldiv_if.sv
// Execute-stage request / Memory-stage completion bundle for the multiply/divide unit.
interface execute_muldiv_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  flushE;
    logic                  startE;
    logic [2:0]            funct3E;
    logic [DATA_WIDTH-1:0] rd1E;
    logic [DATA_WIDTH-1:0] rd2E;
    logic [4:0]            RdE;
    logic                  busyE;
    logic                  doneM;
    logic [DATA_WIDTH-1:0] resultM;
    logic [4:0]            RdM;

    modport master (
        output flushE, startE, funct3E, rd1E, rd2E, RdE,
        input  busyE, doneM, resultM, RdM
    );

    modport slave (
        input  flushE, startE, funct3E, rd1E, rd2E, RdE,
        output busyE, doneM, resultM, RdM
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module muldiv_div_core #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             done_o,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o
);
    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    logic             busy_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] quo_q, quo_d;
    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] dvs_q;
    logic [Width:0]   shifted;
    logic [Width:0]   diff;

    // quo_q starts as the dividend; its top bit feeds the partial remainder each step.
    always_comb begin
        shifted = {rem_q, quo_q[Width-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = diff[Width] ? shifted[Width-1:0] : diff[Width-1:0];
        quo_d   = {quo_q[Width-2:0], ~diff[Width]};
    end

    // Outputs are the values of the final step so the caller can register them at the same edge.
    assign done_o      = busy_q && (cnt_q == LastCnt);
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            if (abort_i || done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit for the Execute stage; stalls the pipeline while iterating.
// Build option MULDIV_FAST_MUL_EN replaces the iterative multiplier with a one-cycle one.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OpWidth
) (
    input logic             clk,
    input logic             rst,
    execute_muldiv_if.slave mdu_io
);
    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic             sel_q, sel_d;  // MUL family: high half; DIV family: remainder
    logic [4:0]       tag_q, tag_d;
    logic [W-1:0]     result_q, result_d;
    logic [4:0]       rdm_q, rdm_d;

    funct3_e          f3;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;
    logic             accept, div_zero, div_ovf;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   acc_step, prod;
    logic             div_start, div_abort, div_done;
    logic [W-1:0]     div_quo, div_rem, div_pick, div_res;

    assign f3       = funct3_e'(mdu_io.funct3E);
    assign a_signed = (f3 != F3Mulhu) && (f3 != F3Divu) && (f3 != F3Remu);
    assign b_signed = a_signed && (f3 != F3Mulhsu);
    assign a_neg    = a_signed && mdu_io.rd1E[W-1];
    assign b_neg    = b_signed && mdu_io.rd2E[W-1];
    assign a_mag    = a_neg ? -mdu_io.rd1E : mdu_io.rd1E;
    assign b_mag    = b_neg ? -mdu_io.rd2E : mdu_io.rd2E;
    assign accept   = (state_q == StIdle) && mdu_io.startE && !mdu_io.flushE;
    assign div_zero = (mdu_io.rd2E == '0);
    assign div_ovf  = b_signed && mdu_io.funct3E[2] && (&mdu_io.rd2E)
                      && (mdu_io.rd1E == {1'b1, {(W - 1){1'b0}}});

    // Shift-add step: add multiplicand to the upper half when the multiplier LSB is set.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
    assign acc_step = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    assign prod     = neg_q ? -acc_step : acc_step;

    assign div_pick = sel_q ? div_rem : div_quo;
    assign div_res  = neg_q ? -div_pick : div_pick;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        sel_d     = sel_q;
        tag_d     = tag_q;
        result_d  = result_q;
        rdm_d     = rdm_q;
        div_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tag_d = mdu_io.RdE;
                    cnt_d = '0;
                    sel_d = mdu_io.funct3E[2] ? mdu_io.funct3E[1] : (f3 != F3Mul);
                    if (!mdu_io.funct3E[2]) begin
                        neg_d = a_neg ^ b_neg;
`ifdef MULDIV_FAST_MUL_EN
                        result_d = (f3 != F3Mul) ? fast_prod[2*W-1:W] : fast_prod[W-1:0];
                        rdm_d    = mdu_io.RdE;
                        state_d  = StDone;
`else
                        acc_d   = {{W{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        state_d = StMul;
`endif
                    end else if (div_zero) begin
                        result_d = mdu_io.funct3E[1] ? mdu_io.rd1E : '1;
                        rdm_d    = mdu_io.RdE;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = mdu_io.funct3E[1] ? '0 : mdu_io.rd1E;
                        rdm_d    = mdu_io.RdE;
                        state_d  = StDone;
                    end else begin
                        // Remainder follows the dividend's sign, quotient the sign product.
                        neg_d     = mdu_io.funct3E[1] ? a_neg : (a_neg ^ b_neg);
                        div_start = 1'b1;
                        state_d   = StDiv;
                    end
                end
            end
            StMul: begin
                if (mdu_io.flushE) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        result_d = sel_q ? prod[2*W-1:W] : prod[W-1:0];
                        rdm_d    = tag_q;
                        state_d  = StDone;
                    end
                end
            end
            StDiv: begin
                if (mdu_io.flushE) begin
                    state_d = StIdle;
                end else if (div_done) begin
                    result_d = div_res;
                    rdm_d    = tag_q;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            rdm_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            rdm_q    <= rdm_d;
        end
    end

    assign div_abort = (state_q == StDiv) && mdu_io.flushE;

    muldiv_div_core #(
        .Width(W)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quotient_o (div_quo),
        .remainder_o(div_rem)
    );

    assign mdu_io.busyE   = accept || (state_q == StMul) || (state_q == StDiv);
    assign mdu_io.doneM   = (state_q == StDone);
    assign mdu_io.resultM = result_q;
    assign mdu_io.RdM     = rdm_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed table, hand-written flush/reset/hold sequences, random ops.
module tb_execute_muldiv;
    localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = W + 1;
`endif
    localparam int DivLat = W + 1;
    localparam int Budget = 100;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    execute_muldiv_if #(.DATA_WIDTH(W)) mdu_if ();

    execute_muldiv #(
        .DATA_WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mdu_io(mdu_if)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain 64-bit arithmetic plus the RISC-V special cases.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: p = sa * sb;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; end
            3'd6: begin if (b == 0) return a; p = sa % sb; end
            default: begin if (b == 0) return a; p = ua % ub; end
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return MulLat;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DivLat;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op; lat counts cycles from the accepting cycle to the doneM cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdm,
                          output int lat, output int busy_n);
        @(negedge clk);
        mdu_if.startE  = 1'b1;
        mdu_if.funct3E = f3;
        mdu_if.rd1E    = a;
        mdu_if.rd2E    = b;
        mdu_if.RdE     = rd;
        #1;
        busy_n = int'(mdu_if.busyE);
        @(negedge clk);
        mdu_if.startE = 1'b0;
        mdu_if.rd1E   = $urandom;
        mdu_if.rd2E   = $urandom;
        mdu_if.RdE    = 5'($urandom);
        #1;
        lat = 1;
        while (!mdu_if.doneM && lat < Budget) begin
            busy_n += int'(mdu_if.busyE);
            @(negedge clk);
            #1;
            lat++;
        end
        res = mdu_if.resultM;
        rdm = mdu_if.RdM;
    endtask

    task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                            input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rdm;
        int          lat, busy_n;
        run_op(f3, a, b, rd, res, rdm, lat, busy_n);
        check({name, " result"}, 64'(res), 64'(exp));
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(busy_n), 64'(exp_lat));
        check({name, " RdM"}, 64'(rdm), 64'(rd));
        @(negedge clk);
        #1;
        check({name, " doneM single pulse"}, 64'(mdu_if.doneM), 64'(0));
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            seen += int'(mdu_if.doneM);
        end
        check(name, 64'(seen), 64'(0));
    endtask

    vec_t tbl[$];

    initial begin
        logic [31:0] exp_prev;
        rst            = 1'b1;
        mdu_if.startE  = 1'b0;
        mdu_if.flushE  = 1'b0;
        mdu_if.funct3E = 3'd0;
        mdu_if.rd1E    = '0;
        mdu_if.rd2E    = '0;
        mdu_if.RdE     = '0;

        tbl.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat});
        tbl.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MulLat});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MulLat});
        tbl.push_back('{3'd0, 32'd6,          32'd7,         32'd42,        MulLat});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DivLat});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DivLat});
        tbl.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        DivLat});
        tbl.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         DivLat});
        tbl.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        tbl.push_back('{3'd6, 32'd5,          32'd0,         32'd5,         1});
        tbl.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        tbl.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1});
        tbl.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        tbl.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
        tbl.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         DivLat});

        repeat (3) @(negedge clk);
        #1;
        check("reset doneM", 64'(mdu_if.doneM), 64'(0));
        check("reset resultM", 64'(mdu_if.resultM), 64'(0));
        check("reset RdM", 64'(mdu_if.RdM), 64'(0));
        check("reset busyE", 64'(mdu_if.busyE), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            check_op($sformatf("table[%0d]", i), tbl[i].f3, tbl[i].a, tbl[i].b, 5'(i + 1),
                     tbl[i].exp, tbl[i].lat);
        end

        // startE held high with changing operands while busy; DONE must not stall or re-accept.
        begin
            int lat = 1;
            @(negedge clk);
            mdu_if.startE  = 1'b1;
            mdu_if.funct3E = 3'd0;
            mdu_if.rd1E    = 32'd7;
            mdu_if.rd2E    = 32'hFFFF_FFFD;
            mdu_if.RdE     = 5'd9;
            @(negedge clk);
            mdu_if.funct3E = 3'd5;
            mdu_if.rd1E    = 32'd1234;
            mdu_if.rd2E    = 32'd0;
            #1;
            while (!mdu_if.doneM && lat < Budget) begin
                @(negedge clk);
                #1;
                lat++;
            end
            check("hold latency", 64'(lat), 64'(MulLat));
            check("hold busyE in DONE", 64'(mdu_if.busyE), 64'(0));
            check("hold result", 64'(mdu_if.resultM), 64'(32'hFFFF_FFEB));
            mdu_if.startE = 1'b0;
            @(negedge clk);
            #1;
            check("hold doneM single pulse", 64'(mdu_if.doneM), 64'(0));
            exp_prev = 32'hFFFF_FFEB;
        end

        // Flush after ten DIV cycles: back to IDLE, no completion, result held.
        @(negedge clk);
        mdu_if.startE  = 1'b1;
        mdu_if.funct3E = 3'd4;
        mdu_if.rd1E    = 32'd100;
        mdu_if.rd2E    = 32'd7;
        mdu_if.RdE     = 5'd3;
        @(negedge clk);
        mdu_if.startE = 1'b0;
        repeat (9) @(negedge clk);
        mdu_if.flushE = 1'b1;
        @(negedge clk);
        mdu_if.flushE = 1'b0;
        #1;
        check("flush DIV busyE", 64'(mdu_if.busyE), 64'(0));
        watch_no_done("flush DIV no doneM", 40);
        check("flush DIV resultM held", 64'(mdu_if.resultM), 64'(exp_prev));
        check_op("DIVU after flush", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, DivLat);

        // Flush while a start is presented in IDLE blocks acceptance.
        @(negedge clk);
        mdu_if.startE  = 1'b1;
        mdu_if.flushE  = 1'b1;
        mdu_if.funct3E = 3'd4;
        mdu_if.rd1E    = 32'd5;
        mdu_if.rd2E    = 32'd0;
        #1;
        check("flush IDLE busyE", 64'(mdu_if.busyE), 64'(0));
        @(negedge clk);
        mdu_if.startE = 1'b0;
        mdu_if.flushE = 1'b0;
        watch_no_done("flush IDLE no doneM", 40);
        check("flush IDLE resultM held", 64'(mdu_if.resultM), 64'(3));

        // Reset in the middle of a multiply clears every output.
        @(negedge clk);
        mdu_if.startE  = 1'b1;
        mdu_if.funct3E = 3'd0;
        mdu_if.rd1E    = 32'd6;
        mdu_if.rd2E    = 32'd7;
        mdu_if.RdE     = 5'd17;
        @(negedge clk);
        mdu_if.startE = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset doneM", 64'(mdu_if.doneM), 64'(0));
        check("mid reset resultM", 64'(mdu_if.resultM), 64'(0));
        check("mid reset RdM", 64'(mdu_if.RdM), 64'(0));
        check("mid reset busyE", 64'(mdu_if.busyE), 64'(0));
        watch_no_done("mid reset no doneM", 40);

        for (int i = 0; i < 48; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            check_op($sformatf("rand[%0d] f3=%0d a=%0h b=%0h", i, f3, a, b), f3, a, b,
                     5'($urandom), ref_result(f3, a, b), ref_latency(f3, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
